// File: rtl/video_pkg.sv
// Shared types and constants for the pixel-stream generator.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_X     = 2'd0,
    PAT_Y     = 2'd1,
    PAT_XY    = 2'd2,
    PAT_CONST = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    IDLE,
    VBLANK,
    ACTIVE,
    HBLANK,
    FEND
  } vgen_state_e;

  // de_period values at or below this produce contiguous DE.
  localparam int unsigned DE_PERIOD_CONTIG = 1;

endpackage

// File: rtl/video_stream_gen_if.sv
// Pixel-stream bus (data, valid, line/frame blanking flags).
interface video_stream_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] do_o;
  logic                  de_o;
  logic                  hs_o;
  logic                  vs_o;

  modport master (output do_o, output de_o, output hs_o, output vs_o);
  modport slave  (input  do_o, input  de_o, input  hs_o, input  vs_o);
endinterface

// File: rtl/video_pattern_pix.sv
// Registered test-pattern mux; pix updates only when load is high and holds otherwise.
module video_pattern_pix import video_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  pattern_e              pattern,
  input  logic [DATA_WIDTH-1:0] fill,
  output logic [DATA_WIDTH-1:0] pix
);

  logic [DATA_WIDTH-1:0] pix_d;

  // Select the pattern value; x+y wraps naturally at DATA_WIDTH bits.
  always_comb begin
    pix_d = fill;
    case (pattern)
      PAT_X:     pix_d = x;
      PAT_Y:     pix_d = y;
      PAT_XY:    pix_d = x + y;
      PAT_CONST: pix_d = fill;
      default:   pix_d = fill;
    endcase
  end

  // Capture the pixel on DE cycles only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix <= '0;
    end else if (load) begin
      pix <= pix_d;
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// Pixel-stream transmitter: programmable geometry, blanking, sparse DE and test patterns.
//
// state  | meaning
// IDLE   | waiting for en with a non-empty geometry; hs=vs=1
// VBLANK | frame blanking, hs=vs=1
// ACTIVE | active part of a line, hs=vs=0, DE on the last cycle of each slot
// HBLANK | line blanking, hs=1 vs=0
// FEND   | one-cycle frame end, counts as first vblank cycle of a following frame
//
// Outputs are registered from the next-state values, so they line up exactly with
// the state they describe.
module video_stream_gen import video_pkg::*; #(
  parameter int DATA_WIDTH   = 8,
  parameter int CNT_WIDTH    = 12,
  parameter int PERIOD_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_WIDTH-1:0]    frame_w,
  input  logic [CNT_WIDTH-1:0]    frame_h,
  input  logic [CNT_WIDTH-1:0]    hblank,
  input  logic [CNT_WIDTH-1:0]    vblank,
  input  logic [PERIOD_WIDTH-1:0] de_period,
  input  logic [1:0]              pattern,
  input  logic [DATA_WIDTH-1:0]   const_i,
  video_stream_gen_if.master      vid,
  output logic [15:0]             frame_cnt_o,
  output logic                    busy_o
);

  localparam logic [CNT_WIDTH-1:0]    CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);

  vgen_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0]    x_q, x_d, y_q, y_d, blank_q, blank_d;
  logic [PERIOD_WIDTH-1:0] slot_q, slot_d;

  // Latched frame configuration; blanking and period are stored as down-counter reloads.
  logic [CNT_WIDTH-1:0]    w_q, h_q, hb_rl_q;
  logic [PERIOD_WIDTH-1:0] p_rl_q;
  pattern_e                pat_q;
  logic [DATA_WIDTH-1:0]   fill_q;

  logic [CNT_WIDTH-1:0]    hb_rl_in, vb_rl_in;
  logic [PERIOD_WIDTH-1:0] p_rl_in;
  logic                    start_ok, latch;
  pattern_e                pat_sel;
  logic [DATA_WIDTH-1:0]   fill_sel, pix;
  logic                    de_d;

  assign start_ok = en && (frame_w != '0) && (frame_h != '0);
  assign hb_rl_in = (hblank == '0) ? '0 : hblank - CNT_ONE;
  assign vb_rl_in = (vblank == '0) ? '0 : vblank - CNT_ONE;
  assign p_rl_in  = (de_period <= PERIOD_WIDTH'(DE_PERIOD_CONTIG)) ? '0 : de_period - PER_ONE;

  // Next-state and counter logic. A frame that is refused at FEND (en low or empty
  // geometry) returns to IDLE rather than running a degenerate frame.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    slot_d  = slot_q;
    blank_d = blank_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          latch   = 1'b1;
          state_d = VBLANK;
          blank_d = vb_rl_in;
        end
      end
      VBLANK: begin
        if (blank_q == '0) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          slot_d  = p_rl_q;
        end else begin
          blank_d = blank_q - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (slot_q == '0) begin
          slot_d = p_rl_q;
          if (x_q == w_q - CNT_ONE) begin
            if (y_q == h_q - CNT_ONE) begin
              state_d = FEND;
            end else begin
              state_d = HBLANK;
              blank_d = hb_rl_q;
            end
          end else begin
            x_d = x_q + CNT_ONE;
          end
        end else begin
          slot_d = slot_q - PER_ONE;
        end
      end
      HBLANK: begin
        if (blank_q == '0) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = y_q + CNT_ONE;
          slot_d  = p_rl_q;
        end else begin
          blank_d = blank_q - CNT_ONE;
        end
      end
      FEND: begin
        if (start_ok) begin
          latch = 1'b1;
          // FEND already provided one blanking cycle.
          if (vb_rl_in == '0) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            slot_d  = p_rl_in;
          end else begin
            state_d = VBLANK;
            blank_d = vb_rl_in - CNT_ONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign de_d     = (state_d == ACTIVE) && (slot_d == '0);
  assign pat_sel  = latch ? pattern_e'(pattern) : pat_q;
  assign fill_sel = latch ? const_i : fill_q;

  // Configuration capture at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      h_q     <= '0;
      hb_rl_q <= '0;
      p_rl_q  <= '0;
      pat_q   <= PAT_X;
      fill_q  <= '0;
    end else if (latch) begin
      w_q     <= frame_w;
      h_q     <= frame_h;
      hb_rl_q <= hb_rl_in;
      p_rl_q  <= p_rl_in;
      pat_q   <= pattern_e'(pattern);
      fill_q  <= const_i;
    end
  end

  // State and position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      slot_q  <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      slot_q  <= slot_d;
      blank_q <= blank_d;
    end
  end

  // Registered stream flags, frame counter and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid.de_o    <= 1'b0;
      vid.hs_o    <= 1'b1;
      vid.vs_o    <= 1'b1;
      busy_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      vid.de_o <= de_d;
      vid.hs_o <= (state_d != ACTIVE);
      vid.vs_o <= !((state_d == ACTIVE) || (state_d == HBLANK));
      busy_o   <= (state_d != IDLE);
      if (state_d == FEND) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

  video_pattern_pix #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pix (
    .clk     (clk),
    .rst     (rst),
    .load    (de_d),
    .x       (x_d[DATA_WIDTH-1:0]),
    .y       (y_d[DATA_WIDTH-1:0]),
    .pattern (pat_sel),
    .fill    (fill_sel),
    .pix     (pix)
  );

  assign vid.do_o = pix;

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen against a frame-level trace model.
module tb_video_stream_gen;

  localparam int DW = 8;
  localparam int CW = 12;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] frame_w, frame_h, hblank, vblank;
  logic [PW-1:0] de_period;
  logic [1:0]    pattern;
  logic [DW-1:0] const_i;
  logic [15:0]   frame_cnt_o;
  logic          busy_o;

  video_stream_gen_if #(.DATA_WIDTH(DW)) vid ();

  video_stream_gen #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .PERIOD_WIDTH(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_w    (frame_w),
    .frame_h    (frame_h),
    .hblank     (hblank),
    .vblank     (vblank),
    .de_period  (de_period),
    .pattern    (pattern),
    .const_i    (const_i),
    .vid        (vid),
    .frame_cnt_o(frame_cnt_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w, h, hb, vb, p, pat, fill;
  } cfg_t;

  typedef struct packed {
    logic        de, hs, vs, busy;
    logic [15:0] fc;
    logic [7:0]  d;
  } exp_t;

  cfg_t cfg_q[$];
  exp_t exp_q[$];
  int   sw_idx[$];
  int   model_fc;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic cfg_t mk_cfg(int w, int h, int hb, int vb, int p, int pat, int fill);
    cfg_t c;
    c.w = w; c.h = h; c.hb = hb; c.vb = vb; c.p = p; c.pat = pat; c.fill = fill;
    return c;
  endfunction

  function automatic logic [7:0] pix_model(cfg_t c, int x, int y);
    case (c.pat)
      0:       return 8'(x % 256);
      1:       return 8'(y % 256);
      2:       return 8'((x + y) % 256);
      default: return 8'(c.fill % 256);
    endcase
  endfunction

  task automatic apply_cfg(cfg_t c);
    frame_w   = CW'(c.w);
    frame_h   = CW'(c.h);
    hblank    = CW'(c.hb);
    vblank    = CW'(c.vb);
    de_period = PW'(c.p);
    pattern   = 2'(c.pat);
    const_i   = 8'(c.fill);
  endtask

  task automatic push(logic de, logic hs, logic vs, logic busy, logic [7:0] d);
    exp_t e;
    e.de = de; e.hs = hs; e.vs = vs; e.busy = busy; e.fc = 16'(model_fc); e.d = d;
    exp_q.push_back(e);
  endtask

  // Expected cycle trace for all frames in cfg_q, followed by a few idle cycles.
  task automatic build_model();
    cfg_t c;
    int   pe, nv, nh, swl;
    logic de;
    exp_q.delete();
    sw_idx.delete();
    for (int k = 0; k < cfg_q.size(); k++) begin
      c   = cfg_q[k];
      pe  = (c.p < 2) ? 1 : c.p;
      nv  = ((c.vb < 1) ? 1 : c.vb) - ((k == 0) ? 0 : 1);
      nh  = (c.hb < 1) ? 1 : c.hb;
      swl = (c.h > 2) ? 2 : c.h - 1;
      for (int i = 0; i < nv; i++) push(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      for (int y = 0; y < c.h; y++) begin
        if (y == swl) sw_idx.push_back(exp_q.size());
        for (int cy = 0; cy < c.w * pe; cy++) begin
          de = ((cy % pe) == pe - 1);
          push(de, 1'b0, 1'b0, 1'b1, de ? pix_model(c, cy / pe, y) : 8'h00);
        end
        if (y < c.h - 1)
          for (int i = 0; i < nh; i++) push(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      end
      model_fc = (model_fc + 1) % 65536;
      push(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    end
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  // Run the frames in cfg_q back to back; mid-frame, switch inputs to the next
  // frame's config (or drop en and scramble inputs on the last frame).
  task automatic run_frames(string name);
    exp_t        e;
    logic [19:0] got, want;
    int          k;
    build_model();
    @(negedge clk);
    apply_cfg(cfg_q[0]);
    en = 1'b1;
    k  = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      e    = exp_q[i];
      got  = {vid.de_o, vid.hs_o, vid.vs_o, busy_o, frame_cnt_o};
      want = {e.de, e.hs, e.vs, e.busy, e.fc};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s ctl cyc %0d: de/hs/vs/busy got %b%b%b%b fc %0d, expected %b%b%b%b fc %0d",
                 name, i, got[19], got[18], got[17], got[16], got[15:0],
                 want[19], want[18], want[17], want[16], want[15:0]);
      end
      if (e.de) begin
        n_vec++;
        if (vid.do_o !== e.d) begin
          n_err++;
          $display("FAIL %s pix cyc %0d: do_o got %02h expected %02h", name, i, vid.do_o, e.d);
        end
      end
      if (k < sw_idx.size() && i == sw_idx[k]) begin
        if (k + 1 < cfg_q.size()) begin
          apply_cfg(cfg_q[k+1]);
        end else begin
          en = 1'b0;
          apply_cfg(mk_cfg($urandom_range(1, 50), $urandom_range(1, 50), $urandom_range(0, 9),
                           $urandom_range(0, 9), $urandom_range(0, 15), $urandom_range(0, 3),
                           $urandom_range(0, 255)));
        end
        k++;
      end
    end
  endtask

  task automatic check_idle_reset(string name, logic [15:0] fc);
    n_vec++;
    if ({vid.de_o, vid.hs_o, vid.vs_o, busy_o, frame_cnt_o, vid.do_o} !== {4'b0110, fc, 8'h00}) begin
      n_err++;
      $display("FAIL %s: de/hs/vs/busy got %b%b%b%b fc %0d do %02h, expected 0110 fc %0d do 00",
               name, vid.de_o, vid.hs_o, vid.vs_o, busy_o, frame_cnt_o, vid.do_o, fc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_fc = 0;
  endtask

  task automatic test_reset();
    apply_cfg(mk_cfg(8, 8, 4, 10, 4, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_reset("reset_held", 16'd0);
    rst = 1'b0;
    model_fc = 0;
    @(negedge clk);
    check_idle_reset("reset_released", 16'd0);
  endtask

  task automatic test_basic();
    do_reset();
    cfg_q = '{mk_cfg(8, 8, 4, 10, 4, 0, 0), mk_cfg(8, 8, 4, 10, 4, 0, 0)};
    run_frames("basic_8x8_p4");
    n_vec++;
    if (frame_cnt_o !== 16'd2) begin
      n_err++;
      $display("FAIL basic_frame_cnt: got %0d expected 2", frame_cnt_o);
    end
  endtask

  task automatic test_xy_contig();
    do_reset();
    cfg_q = '{mk_cfg(8, 4, 3, 2, 0, 2, 0)};
    run_frames("xy_8x4_p0");
  endtask

  task automatic test_en_drop();
    do_reset();
    cfg_q = '{mk_cfg(8, 8, 2, 3, 1, 1, 0)};
    run_frames("en_drop");
    n_vec++;
    if (frame_cnt_o !== 16'd1) begin
      n_err++;
      $display("FAIL en_drop_frame_cnt: got %0d expected 1", frame_cnt_o);
    end
  endtask

  task automatic test_cfg_change();
    do_reset();
    cfg_q = '{mk_cfg(8, 8, 2, 2, 2, 0, 0), mk_cfg(4, 8, 2, 2, 2, 0, 0)};
    run_frames("cfg_change");
  endtask

  task automatic test_mid_reset();
    int waited;
    do_reset();
    @(negedge clk);
    apply_cfg(mk_cfg(8, 8, 2, 3, 1, 0, 0));
    en = 1'b1;
    waited = 0;
    while (vid.de_o !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited >= 100) begin
      n_err++;
      $display("FAIL mid_reset_wait_de: de_o got %b expected 1 within 100 cycles", vid.de_o);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("mid_reset", 16'd0);
    rst = 1'b0;
    en  = 1'b0;
    model_fc = 0;
    @(negedge clk);
    check_idle_reset("mid_reset_idle", 16'd0);
    cfg_q = '{mk_cfg(5, 3, 1, 4, 3, 2, 0)};
    run_frames("after_mid_reset");
  endtask

  task automatic test_zero_w();
    do_reset();
    @(negedge clk);
    apply_cfg(mk_cfg(0, 4, 2, 2, 1, 0, 0));
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_idle_reset("zero_w", 16'd0);
    end
    en = 1'b0;
  endtask

  task automatic test_wide();
    do_reset();
    cfg_q = '{mk_cfg(300, 2, 2, 2, 1, 0, 0), mk_cfg(300, 2, 2, 1, 0, 3, 8'hA5)};
    run_frames("wide_300");
  endtask

  task automatic test_back_to_back();
    int nf;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      cfg_q.delete();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++)
        cfg_q.push_back(mk_cfg($urandom_range(1, 16), $urandom_range(1, 5), $urandom_range(0, 4),
                               $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3),
                               $urandom_range(0, 255)));
      run_frames("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    model_fc = 0;
    apply_cfg(mk_cfg(0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_basic();
    test_xy_contig();
    test_en_drop();
    test_cfg_change();
    test_mid_reset();
    test_zero_w();
    test_wide();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_stream_gen.md
Name: video_stream_gen

Overview:
- Synthesizable transmitter for the team's pixel-stream interface (do/de/hs/vs), i.e. the producer side that scaler_h, scaler_v and the bench monitor consume.
- Generates frames of programmable geometry, line/frame blanking and sparse-DE pacing, with selectable test patterns.
- Used on hardware as a built-in scaler stimulus source and in benches as a cycle-exact replacement for behavioural BMP drivers.

Parameters:
- DATA_WIDTH, 8, pixel width of do_o.
- CNT_WIDTH, 12, width of geometry, blanking and position counters (max frame 4095x4095).
- PERIOD_WIDTH, 4, width of de_period.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  run request; sampled at frame boundaries.
- frame_w  in  CNT_WIDTH  active pixels per line.
- frame_h  in  CNT_WIDTH  active lines per frame.
- hblank  in  CNT_WIDTH  cycles of hs high between lines (0 treated as 1).
- vblank  in  CNT_WIDTH  cycles of vs high between frames (0 treated as 1).
- de_period  in  PERIOD_WIDTH  cycles per pixel slot; 0 or 1 means contiguous DE; P>=2 means P-1 empty cycles then one DE.
- pattern  in  2  0 = x ramp, 1 = y ramp, 2 = x+y, 3 = constant.
- const_i  in  DATA_WIDTH  fill value for pattern 3.
- do_o  out  DATA_WIDTH  pixel data; valid only when de_o=1.
- de_o  out  1  pixel valid.
- hs_o  out  1  high during line blanking, low across the active part of a line.
- vs_o  out  1  high during frame blanking, low across all active lines.
- frame_cnt_o  out  16  completed frames, wraps at 2^16.
- busy_o  out  1  high from frame start until return to IDLE.

Behaviour:
- All outputs registered.
- Reset values:
  - do_o=0, de_o=0, hs_o=1, vs_o=1, frame_cnt_o=0, busy_o=0.
  - state=IDLE; all counters cleared.
- Reset mid-operation: outputs take reset values on the cycle after rst is sampled high; the frame in progress is abandoned without notice.
- FSM states:
  - IDLE: hs=1, vs=1, de=0.
    - If en=1 and frame_w!=0 and frame_h!=0: latch all config inputs and go to VBLANK next cycle.
    - Otherwise stay in IDLE.
  - VBLANK: hs=1, vs=1, de=0 for max(vblank,1) cycles, then ACTIVE with x=0, y=0.
  - ACTIVE: hs=0, vs=0.
    - Line lasts frame_w*max(P,1) cycles.
    - de_o=1 on the last cycle of each P-cycle slot; do_o is driven on that same cycle.
    - x increments after each DE.
    - After the last pixel of a line:
      - if y<frame_h-1, go to HBLANK;
      - else go to FEND.
  - HBLANK: hs=1, vs=0, de=0 for max(hblank,1) cycles, then y+1, x=0, ACTIVE.
  - FEND: one cycle with hs=1, vs=1; frame_cnt_o increments.
    - If en=1: relatch config, then VBLANK (the FEND cycle counts as the first vblank cycle).
    - If en=0: go to IDLE.
- Config is latched only at frame start. Input changes mid-frame have no effect until the next frame.
- en=0 mid-frame: the current frame completes in full, then the FSM goes to IDLE.
- Pattern data:
  - x ramp: x[DATA_WIDTH-1:0].
  - y ramp: y[DATA_WIDTH-1:0].
  - x+y: (x+y) truncated to DATA_WIDTH bits, wraps naturally.
  - constant: latched const_i.
- Transitions are edge-exact; there is no pipeline latency between state and outputs.
- do_o holds its last value when de_o=0.
- busy_o=0 only in IDLE.

Decomposition:
- Shared package video_pkg:
  - pattern_e enum (PAT_X, PAT_Y, PAT_XY, PAT_CONST);
  - vgen_state_e (IDLE, VBLANK, ACTIVE, HBLANK, FEND);
  - DE_PERIOD_CONTIG constant.
- One natural sub-module, video_pattern_pix: registered pattern mux from (x, y, pattern, const).
- Timing FSM and counters stay in video_stream_gen.

Test Plan:
- 8x8, P=4, hblank=4, vblank=10, pattern x, en held high:
  - line is 32 cycles with DE on slot cycles 3,7,…,31;
  - do_o = 0..7 per line;
  - 64 DEs per frame;
  - vs_o falls on the first ACTIVE cycle;
  - frame_cnt_o = 2 after 2 frames.
- 8x4, P=0, pattern x+y: 8 contiguous DE cycles per line; line 3 carries 3..10; hs_o low for exactly 8 cycles per line.
- en dropped at line 2 of frame 0: all 8 lines still emitted; FEND then IDLE (hs=vs=1, busy_o=0); frame_cnt_o = 1.
- frame_w changed 8→4 during frame 0: frame 0 has 8 pixels/line, frame 1 has 4 pixels/line.
- rst pulsed mid-ACTIVE: next cycle de=0, hs=vs=1, frame_cnt_o=0; a fresh frame starts from vblank once en=1.
- frame_w=0 with en=1: stays in IDLE with no DE. Pattern const, const_i=0xA5, 300x2: all DEs carry 0xA5, and x wraps to 0 after 255 in pattern 0.
